// File: rtl/enm_fire_sched.sv
// ---------------------------------------------------------------------------
// enm_fire_sched
//
// Enemy bullet scheduler. Up to four enemies each run a cooldown counter. When
// an enemy's cooldown expires it requests a shot. A round-robin arbiter picks
// at most one requester per tick. The winner gets the lowest free slot in an
// 8-entry bullet pool. A registered one-cycle launch pulse then carries the
// slot, the enemy index and a per-enemy rotating direction. Slots stay busy
// until the bullet logic returns them through slot_release.
//
// Ports
//   clk22        in   game tick clock, rising-edge active
//   rst          in   synchronous active-high reset
//   gamestart    in   synchronous clear, identical in effect to rst
//   fire_en      in   game FSM permits new launches
//   enm_alive    in   [3:0] bit i = enemy i alive
//   slot_release in   [7:0] bit k pulse = bullet in slot k is gone
//   launch       out  one-cycle pulse, a bullet is launched
//   launch_slot  out  [2:0] pool slot of this launch
//   launch_enm   out  [1:0] enemy owning this launch
//   launch_dir   out  [1:0] 0 down, 1 down-left, 2 down-right
//   slot_busy    out  [7:0] bit k = slot k holds a live bullet
//   drop_cnt     out  [7:0] cycles blocked by a full pool, saturating
//
// Parameter
//   COOLDOWN     ticks between two grants to the same enemy, 1..15
// ---------------------------------------------------------------------------
module enm_fire_sched #(
    parameter int unsigned COOLDOWN = 8
) (
    input  logic       clk22,
    input  logic       rst,
    input  logic       gamestart,
    input  logic       fire_en,
    input  logic [3:0] enm_alive,
    input  logic [7:0] slot_release,
    output logic       launch,
    output logic [2:0] launch_slot,
    output logic [1:0] launch_enm,
    output logic [1:0] launch_dir,
    output logic [7:0] slot_busy,
    output logic [7:0] drop_cnt
);

    localparam logic [3:0] CD_LOAD = 4'(COOLDOWN);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2
    } state_t;

    // -----------------------------------------------------------------------
    // State
    // -----------------------------------------------------------------------
    state_t     state_reg;
    logic [3:0] cnt_reg [4];
    logic [1:0] dir_reg [4];
    logic [1:0] rr_ptr_reg;
    logic       launch_reg;
    logic [2:0] launch_slot_reg;
    logic [1:0] launch_enm_reg;
    logic [1:0] launch_dir_reg;
    logic [7:0] slot_busy_reg;
    logic [7:0] drop_cnt_reg;

    // -----------------------------------------------------------------------
    // Request generation: an enemy asks to fire only while running, alive and
    // with its cooldown fully expired.
    // -----------------------------------------------------------------------
    logic [3:0] req;

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_req
            assign req[gi] = (state_reg == RUN) && enm_alive[gi] && (cnt_reg[gi] == 4'd0);
        end
    endgenerate

    // -----------------------------------------------------------------------
    // Round-robin pick. The search walks rr_ptr, rr_ptr+1, ... with 2-bit
    // wrap. Iterating offsets from high to low lets the smallest offset win.
    // -----------------------------------------------------------------------
    function automatic logic [2:0] rr_pick(input logic [3:0] r, input logic [1:0] p);
        logic [2:0] res;
        logic [1:0] idx;
        res = 3'b000;
        for (int k = 3; k >= 0; k--) begin
            idx = p + 2'(k);
            if (r[idx]) begin
                res = {1'b1, idx};
            end
        end
        return res;
    endfunction

    // Lowest-index free slot. Only meaningful while the pool is not full.
    function automatic logic [2:0] first_free(input logic [7:0] busy);
        logic [2:0] res;
        res = 3'd0;
        for (int k = 7; k >= 0; k--) begin
            if (!busy[k]) begin
                res = 3'(k);
            end
        end
        return res;
    endfunction

    logic [2:0] pick;
    logic       any_req;
    logic       pool_full;
    logic       grant_valid;
    logic [1:0] grant_idx;
    logic [2:0] alloc_slot;
    logic [7:0] alloc_mask;
    logic       drop;

    always_comb begin
        pick        = rr_pick(req, rr_ptr_reg);
        any_req     = |req;
        pool_full   = &slot_busy_reg;
        // A full pool blocks the grant entirely, so the requester keeps its
        // zero cooldown and retries on the following tick.
        grant_valid = pick[2] && !pool_full;
        grant_idx   = pick[1:0];
        alloc_slot  = first_free(slot_busy_reg);
        alloc_mask  = grant_valid ? (8'b0000_0001 << alloc_slot) : 8'b0000_0000;
        drop        = any_req && pool_full;
    end

    // -----------------------------------------------------------------------
    // Sequential update: FSM, counters, pool and registered launch outputs.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk22) begin
        if (rst || gamestart) begin
            state_reg       <= IDLE;
            rr_ptr_reg      <= 2'd0;
            launch_reg      <= 1'b0;
            launch_slot_reg <= 3'd0;
            launch_enm_reg  <= 2'd0;
            launch_dir_reg  <= 2'd0;
            slot_busy_reg   <= 8'h00;
            drop_cnt_reg    <= 8'h00;
            for (int i = 0; i < 4; i++) begin
                cnt_reg[i] <= CD_LOAD;
                dir_reg[i] <= 2'd0;
            end
        end else begin
            case (state_reg)
                IDLE:    if (fire_en)  state_reg <= RUN;
                RUN:     if (!fire_en) state_reg <= HOLD;
                HOLD:    if (fire_en)  state_reg <= RUN;
                default: state_reg <= IDLE;
            endcase

            launch_reg <= grant_valid;
            if (grant_valid) begin
                launch_slot_reg <= alloc_slot;
                launch_enm_reg  <= grant_idx;
                launch_dir_reg  <= dir_reg[grant_idx];
                rr_ptr_reg      <= grant_idx + 2'd1;
            end

            // The allocated slot is always free here. A release of that same
            // slot in this cycle is therefore a release of a free slot, and
            // the allocation wins.
            slot_busy_reg <= (slot_busy_reg & ~slot_release) | alloc_mask;

            if (drop && (drop_cnt_reg != 8'hFF)) begin
                drop_cnt_reg <= drop_cnt_reg + 8'd1;
            end

            for (int i = 0; i < 4; i++) begin
                if (!enm_alive[i]) begin
                    // A dead enemy is parked at a full cooldown, so a revived
                    // enemy waits a full cooldown before its first shot.
                    cnt_reg[i] <= CD_LOAD;
                end else if (grant_valid && (grant_idx == 2'(i))) begin
                    cnt_reg[i] <= CD_LOAD;
                    dir_reg[i] <= (dir_reg[i] == 2'd2) ? 2'd0 : dir_reg[i] + 2'd1;
                end else if ((state_reg == RUN) && (cnt_reg[i] != 4'd0)) begin
                    cnt_reg[i] <= cnt_reg[i] - 4'd1;
                end
            end
        end
    end

    assign launch      = launch_reg;
    assign launch_slot = launch_slot_reg;
    assign launch_enm  = launch_enm_reg;
    assign launch_dir  = launch_dir_reg;
    assign slot_busy   = slot_busy_reg;
    assign drop_cnt    = drop_cnt_reg;

endmodule

// File: tb/tb_enm_fire_sched.sv
// ---------------------------------------------------------------------------
// tb_enm_fire_sched
//
// Directed bench for enm_fire_sched with COOLDOWN = 8. Inputs are driven and
// outputs are sampled 1 ns after each rising edge of clk22. Each scenario task
// makes its own comparisons against hand-derived expected values.
// ---------------------------------------------------------------------------
module tb_enm_fire_sched;

    logic       clk22;
    logic       rst;
    logic       gamestart;
    logic       fire_en;
    logic [3:0] enm_alive;
    logic [7:0] slot_release;
    logic       launch;
    logic [2:0] launch_slot;
    logic [1:0] launch_enm;
    logic [1:0] launch_dir;
    logic [7:0] slot_busy;
    logic [7:0] drop_cnt;

    int errors = 0;
    int checks = 0;

    enm_fire_sched #(.COOLDOWN(8)) dut (
        .clk22        (clk22),
        .rst          (rst),
        .gamestart    (gamestart),
        .fire_en      (fire_en),
        .enm_alive    (enm_alive),
        .slot_release (slot_release),
        .launch       (launch),
        .launch_slot  (launch_slot),
        .launch_enm   (launch_enm),
        .launch_dir   (launch_dir),
        .slot_busy    (slot_busy),
        .drop_cnt     (drop_cnt)
    );

    initial clk22 = 1'b0;
    always #5 clk22 = ~clk22;

    task automatic step();
        @(posedge clk22);
        #1;
    endtask

    task automatic do_reset();
        rst          = 1'b1;
        gamestart    = 1'b0;
        fire_en      = 1'b0;
        enm_alive    = 4'b0000;
        slot_release = 8'h00;
        step();
        step();
        rst = 1'b0;
    endtask

    // -----------------------------------------------------------------------
    task automatic test_reset();
        int n;
        do_reset();
        checks++;
        if (launch !== 1'b0) begin
            errors++; $display("FAIL reset_launch: got %b want 0", launch);
        end
        checks++;
        if (slot_busy !== 8'h00) begin
            errors++; $display("FAIL reset_slot_busy: got %h want 00", slot_busy);
        end
        checks++;
        if (drop_cnt !== 8'h00) begin
            errors++; $display("FAIL reset_drop_cnt: got %0d want 0", drop_cnt);
        end
        checks++;
        if ({launch_slot, launch_enm, launch_dir} !== 7'd0) begin
            errors++;
            $display("FAIL reset_fields: got slot=%0d enm=%0d dir=%0d want 0/0/0",
                     launch_slot, launch_enm, launch_dir);
        end
        // With fire_en low the scheduler stays idle even with everyone alive.
        enm_alive = 4'b1111;
        n = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (launch === 1'b1) n++;
        end
        checks++;
        if (n !== 0) begin
            errors++; $display("FAIL idle_no_launch: got %0d launches want 0", n);
        end
        $display("test_reset done");
    endtask

    // -----------------------------------------------------------------------
    // All four alive: first launch at edge 10, then enemies 1..3, a second
    // round at edges 19..22, and then the pool is full and drops start.
    task automatic test_fill_and_drop();
        int exp_edge [8] = '{10, 11, 12, 13, 19, 20, 21, 22};
        int exp_enm  [8] = '{0, 1, 2, 3, 0, 1, 2, 3};
        int exp_dir  [8] = '{0, 0, 0, 0, 1, 1, 1, 1};
        int li;
        int n;
        logic exp_l;
        do_reset();
        enm_alive = 4'b1111;
        fire_en   = 1'b1;
        li = 0;
        for (int e = 1; e <= 40; e++) begin
            step();
            exp_l = (li < 8) && (exp_edge[li] == e);
            checks++;
            if (launch !== exp_l) begin
                errors++; $display("FAIL fill_launch_e%0d: got %b want %b", e, launch, exp_l);
            end
            if (exp_l) begin
                $display("launch edge=%0d slot=%0d enm=%0d dir=%0d", e, launch_slot, launch_enm, launch_dir);
                checks++;
                if (launch_enm !== 2'(exp_enm[li]) || launch_slot !== 3'(li) ||
                    launch_dir !== 2'(exp_dir[li])) begin
                    errors++;
                    $display("FAIL fill_fields_e%0d: got slot=%0d enm=%0d dir=%0d want %0d/%0d/%0d",
                             e, launch_slot, launch_enm, launch_dir, li, exp_enm[li], exp_dir[li]);
                end
                li++;
            end
            checks++;
            if (drop_cnt !== 8'((e >= 28) ? e - 27 : 0)) begin
                errors++;
                $display("FAIL drop_e%0d: got %0d want %0d", e, drop_cnt, (e >= 28) ? e - 27 : 0);
            end
        end
        n = 0;
        for (int e = 41; e <= 300; e++) begin
            step();
            if (launch === 1'b1) n++;
        end
        checks++;
        if (n !== 0) begin
            errors++; $display("FAIL full_no_launch: got %0d launches want 0", n);
        end
        checks++;
        if (drop_cnt !== 8'hFF) begin
            errors++; $display("FAIL drop_saturate: got %0d want 255", drop_cnt);
        end
        checks++;
        if (slot_busy !== 8'hFF) begin
            errors++; $display("FAIL full_busy: got %h want ff", slot_busy);
        end
        $display("test_fill_and_drop done");
    endtask

    // -----------------------------------------------------------------------
    // Continues from a full pool with rr_ptr = 0 and all enemies pending.
    task automatic test_release();
        slot_release = 8'h20;
        step();
        slot_release = 8'h00;
        checks++;
        if (slot_busy !== 8'hDF || launch !== 1'b0) begin
            errors++; $display("FAIL rel5_clear: got busy=%h launch=%b want df/0", slot_busy, launch);
        end
        step();
        $display("launch slot=%0d enm=%0d dir=%0d", launch_slot, launch_enm, launch_dir);
        checks++;
        if (launch !== 1'b1 || launch_slot !== 3'd5 || launch_enm !== 2'd0 || launch_dir !== 2'd2) begin
            errors++;
            $display("FAIL rel5_launch: got l=%b slot=%0d enm=%0d dir=%0d want 1/5/0/2",
                     launch, launch_slot, launch_enm, launch_dir);
        end
        checks++;
        if (slot_busy !== 8'hFF) begin
            errors++; $display("FAIL rel5_busy: got %h want ff", slot_busy);
        end
        // Free slot 2, then release slot 6 in the same cycle that slot 2 is
        // allocated.
        slot_release = 8'h04;
        step();
        slot_release = 8'h40;
        checks++;
        if (slot_busy !== 8'hFB || launch !== 1'b0) begin
            errors++; $display("FAIL rel2_clear: got busy=%h launch=%b want fb/0", slot_busy, launch);
        end
        step();
        slot_release = 8'h00;
        $display("launch slot=%0d enm=%0d dir=%0d", launch_slot, launch_enm, launch_dir);
        checks++;
        if (launch !== 1'b1 || launch_slot !== 3'd2 || launch_enm !== 2'd1 || launch_dir !== 2'd2) begin
            errors++;
            $display("FAIL rel2_launch: got l=%b slot=%0d enm=%0d dir=%0d want 1/2/1/2",
                     launch, launch_slot, launch_enm, launch_dir);
        end
        checks++;
        if (slot_busy !== 8'hBF) begin
            errors++; $display("FAIL rel_alloc_same_cycle: got %h want bf", slot_busy);
        end
        step();
        $display("launch slot=%0d enm=%0d dir=%0d", launch_slot, launch_enm, launch_dir);
        checks++;
        if (launch !== 1'b1 || launch_slot !== 3'd6 || launch_enm !== 2'd2 || slot_busy !== 8'hFF) begin
            errors++;
            $display("FAIL rel6_launch: got l=%b slot=%0d enm=%0d busy=%h want 1/6/2/ff",
                     launch, launch_slot, launch_enm, slot_busy);
        end
        $display("test_release done");
    endtask

    // -----------------------------------------------------------------------
    task automatic test_hold();
        int n;
        do_reset();
        enm_alive = 4'b1111;
        fire_en   = 1'b1;
        for (int i = 0; i < 10; i++) step();
        checks++;
        if (launch !== 1'b1 || launch_enm !== 2'd0 || launch_slot !== 3'd0) begin
            errors++;
            $display("FAIL hold_first: got l=%b enm=%0d slot=%0d want 1/0/0", launch, launch_enm, launch_slot);
        end
        // The grant decided in the last RUN cycle still completes.
        fire_en = 1'b0;
        step();
        checks++;
        if (launch !== 1'b1 || launch_enm !== 2'd1 || launch_slot !== 3'd1) begin
            errors++;
            $display("FAIL hold_last_run: got l=%b enm=%0d slot=%0d want 1/1/1", launch, launch_enm, launch_slot);
        end
        n = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (launch === 1'b1) n++;
        end
        checks++;
        if (n !== 0) begin
            errors++; $display("FAIL hold_no_launch: got %0d launches want 0", n);
        end
        checks++;
        if (slot_busy !== 8'h03) begin
            errors++; $display("FAIL hold_busy_kept: got %h want 03", slot_busy);
        end
        slot_release = 8'h01;
        step();
        slot_release = 8'h00;
        checks++;
        if (slot_busy !== 8'h02 || launch !== 1'b0) begin
            errors++; $display("FAIL hold_release: got busy=%h launch=%b want 02/0", slot_busy, launch);
        end
        fire_en = 1'b1;
        step();
        checks++;
        if (launch !== 1'b0) begin
            errors++; $display("FAIL hold_resume_gap: got %b want 0", launch);
        end
        step();
        $display("launch slot=%0d enm=%0d dir=%0d", launch_slot, launch_enm, launch_dir);
        checks++;
        if (launch !== 1'b1 || launch_enm !== 2'd2 || launch_slot !== 3'd0 || launch_dir !== 2'd0) begin
            errors++;
            $display("FAIL hold_resume1: got l=%b enm=%0d slot=%0d dir=%0d want 1/2/0/0",
                     launch, launch_enm, launch_slot, launch_dir);
        end
        step();
        checks++;
        if (launch !== 1'b1 || launch_enm !== 2'd3 || launch_slot !== 3'd2) begin
            errors++;
            $display("FAIL hold_resume2: got l=%b enm=%0d slot=%0d want 1/3/2", launch, launch_enm, launch_slot);
        end
        $display("test_hold done");
    endtask

    // -----------------------------------------------------------------------
    task automatic test_single_enemy();
        int exp_edge [4] = '{10, 19, 28, 37};
        int exp_dir  [4] = '{0, 1, 2, 0};
        int li;
        logic exp_l;
        do_reset();
        enm_alive = 4'b0100;
        fire_en   = 1'b1;
        li = 0;
        for (int e = 1; e <= 40; e++) begin
            step();
            exp_l = (li < 4) && (exp_edge[li] == e);
            checks++;
            if (launch !== exp_l) begin
                errors++; $display("FAIL single_launch_e%0d: got %b want %b", e, launch, exp_l);
            end
            if (exp_l) begin
                $display("launch edge=%0d slot=%0d enm=%0d dir=%0d", e, launch_slot, launch_enm, launch_dir);
                checks++;
                if (launch_enm !== 2'd2 || launch_slot !== 3'(li) || launch_dir !== 2'(exp_dir[li])) begin
                    errors++;
                    $display("FAIL single_fields_e%0d: got slot=%0d enm=%0d dir=%0d want %0d/2/%0d",
                             e, launch_slot, launch_enm, launch_dir, li, exp_dir[li]);
                end
                li++;
            end
        end
        $display("test_single_enemy done");
    endtask

    // -----------------------------------------------------------------------
    task automatic test_gamestart();
        int  n;
        logic found;
        do_reset();
        enm_alive = 4'b1111;
        fire_en   = 1'b1;
        for (int i = 0; i < 30; i++) step();
        checks++;
        if (drop_cnt !== 8'd3) begin
            errors++; $display("FAIL gs_pre_drop: got %0d want 3", drop_cnt);
        end
        slot_release = 8'h08;
        step();
        checks++;
        if (slot_busy !== 8'hF7) begin
            errors++; $display("FAIL gs_pre_busy: got %h want f7", slot_busy);
        end
        // A grant for slot 3 is being decided in this cycle.
        gamestart    = 1'b1;
        slot_release = 8'hFF;
        step();
        gamestart    = 1'b0;
        slot_release = 8'h00;
        checks++;
        if (launch !== 1'b0 || slot_busy !== 8'h00 || drop_cnt !== 8'h00) begin
            errors++;
            $display("FAIL gs_clear: got l=%b busy=%h drop=%0d want 0/00/0", launch, slot_busy, drop_cnt);
        end
        checks++;
        if ({launch_slot, launch_enm, launch_dir} !== 7'd0) begin
            errors++;
            $display("FAIL gs_fields: got slot=%0d enm=%0d dir=%0d want 0/0/0", launch_slot, launch_enm, launch_dir);
        end
        // Back in IDLE with fire_en high: the first launch repeats reset timing.
        found = 1'b0;
        n = 0;
        for (int i = 1; i <= 30; i++) begin
            step();
            if (launch === 1'b1) begin
                found = 1'b1;
                n = i;
                break;
            end
        end
        checks++;
        if (!found || n != 10) begin
            errors++; $display("FAIL gs_restart_latency: got found=%b edge=%0d want 1/10", found, n);
        end
        checks++;
        if (launch_enm !== 2'd0 || launch_slot !== 3'd0 || launch_dir !== 2'd0) begin
            errors++;
            $display("FAIL gs_restart_fields: got slot=%0d enm=%0d dir=%0d want 0/0/0",
                     launch_slot, launch_enm, launch_dir);
        end
        $display("test_gamestart done");
    endtask

    initial begin
        rst          = 1'b1;
        gamestart    = 1'b0;
        fire_en      = 1'b0;
        enm_alive    = 4'b0000;
        slot_release = 8'h00;
        test_reset();
        test_fill_and_drop();
        test_release();
        test_hold();
        test_single_enemy();
        test_gamestart();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/enm_fire_sched.md
ENM_FIRE_SCHED -- requirements
Module: enm_fire_sched

Interface
REQ-001 Parameter COOLDOWN, default 8, meaning clk22 ticks between two grants to the same enemy, legal range 1..15.
REQ-002 clk22  in  1  game tick clock; all state changes on its rising edge.
REQ-003 rst  in  1  reset, synchronous, active-high; clock clk22.
REQ-004 gamestart  in  1  synchronous clear, same effect as rst.
REQ-005 fire_en  in  1  game FSM permits new launches.
REQ-006 enm_alive  in  4  bit i = enemy i alive.
REQ-007 slot_release  in  8  bit k pulse = bullet slot k left screen or hit player.
REQ-008 launch  out  1  one-cycle pulse, a bullet is launched.
REQ-009 launch_slot  out  3  slot index allocated for this launch.
REQ-010 launch_enm  out  2  enemy index owning this launch.
REQ-011 launch_dir  out  2  0 = straight down, 1 = down-left, 2 = down-right; 3 never driven.
REQ-012 slot_busy  out  8  bit k = slot k holds a live bullet.
REQ-013 drop_cnt  out  8  cycles in which a request was blocked by a full pool, saturating.

Function
REQ-014 State machine SHALL have states IDLE, RUN, HOLD; IDLE->RUN when fire_en=1; RUN->HOLD when fire_en=0; HOLD->RUN when fire_en=1.
REQ-015 Per-enemy 4-bit cooldown counter cnt[i] SHALL decrement by 1 each cycle in RUN while nonzero and alive; hold in IDLE/HOLD.
REQ-016 While enm_alive[i]=0, cnt[i] SHALL be forced to COOLDOWN so a revived enemy waits a full cooldown.
REQ-017 Request req[i] SHALL equal state==RUN and enm_alive[i] and cnt[i]==0.
REQ-018 Arbiter SHALL grant at most one enemy per cycle, round-robin: search order rr_ptr, rr_ptr+1, ... mod 4.
REQ-019 After a grant to enemy i, rr_ptr SHALL become (i+1) mod 4 and cnt[i] SHALL load COOLDOWN; with no grant rr_ptr SHALL hold.
REQ-020 Allocated slot SHALL be the lowest index k with slot_busy[k]=0, evaluated on current (registered) slot_busy.
REQ-021 If any req is set and all 8 slots busy: no grant, cnt and rr_ptr unchanged (request stays pending), drop_cnt increments, saturating at 255.
REQ-022 Grant decided in cycle N SHALL produce launch=1 with launch_slot/enm/dir registered in cycle N+1, and slot_busy[k] set from cycle N+1; launch=0 all other cycles; launch_slot/enm/dir hold last value when launch=0.
REQ-023 Per-enemy 2-bit direction counter SHALL supply launch_dir and advance 0->1->2->0 on each grant to that enemy.
REQ-024 slot_release[k]=1 SHALL clear slot_busy[k] at the next edge in every state; release of an already free slot is ignored.
REQ-025 Release and allocation of different slots in one cycle SHALL both take effect; a slot released in cycle N is allocatable no earlier than cycle N+1.
REQ-026 Entering HOLD SHALL not clear slot_busy; in-flight bullets remain owned until released.

Reset
REQ-027 On rst or gamestart at an edge: state=IDLE, slot_busy=0, launch=0, launch_slot=0, launch_enm=0, launch_dir=0, drop_cnt=0, rr_ptr=0, all dir counters=0, all cnt[i]=COOLDOWN.
REQ-028 rst/gamestart mid-operation SHALL discard any grant decided that cycle (no launch pulse follows) and override simultaneous slot_release.

Verification
REQ-029 Reset, fire_en=1, enm_alive=4'b1111, no releases -> first launch COOLDOWN+2 cycles after fire_en rises (1 cycle IDLE->RUN, COOLDOWN decrements, 1 registration) with enm=0, slot=0, dir=0; next three cycles enm=1,2,3 slots 1,2,3.
REQ-030 All four alive, no releases, COOLDOWN=8 -> exactly 8 launches, slots 0..7 filled, then drop_cnt increments each cycle to 255 and holds.
REQ-031 Pool full, slot_release=8'b0010_0000 -> next launch uses slot 5, issued to the enemy at rr_ptr, one cycle after slot_busy[5] clears.
REQ-032 enm_alive=4'b0100 only -> launches only with enm=2, spaced COOLDOWN+1 cycles, dir sequence 0,1,2,0.
REQ-033 fire_en dropped while requests pending -> no launch in HOLD, releases still clear slot_busy; fire_en restored -> launches resume with unchanged rr_ptr.
REQ-034 gamestart pulse in same cycle as a grant and slot_release=8'hFF -> next cycle launch=0, slot_busy=0, drop_cnt=0, state IDLE.
